// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and forwarding controller for a 5-stage MIPS pipeline. It keeps its
//   own copy of the D/X, X/M and M/W instruction tags and derives the operand
//   bypass selects, the store-data bypass, the load-use stall, the HI/LO
//   MULT/DIV interlock and a stall-cycle counter from them.
//
// Ports
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   d_*                 : decode-stage (F/D) instruction description
//   branch_taken        : execute resolved a taken branch/jump this cycle
//   stall               : hold PC and F/D, bubble into D/X
//   flush_dx            : load a bubble into D/X
//   fwd_a / fwd_b       : D/X operand select, 00 regfile, 01 MX, 10 WX
//   fwd_wm              : X/M store data taken from the writeback value
//   muldiv_busy         : HI/LO unit occupied
//   stall_cycles        : saturating count of cycles with stall=1
//
// Pipeline contract: the pipeline advances every cycle. When stall=1 the F/D
// register holds and D/X takes a bubble; when branch_taken=1 the F/D
// instruction is wrong-path and D/X also takes a bubble.
module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MULDIV_LAT  = 4,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   d_valid,
  input  logic [REG_ADDR_W-1:0]  d_rs,
  input  logic [REG_ADDR_W-1:0]  d_rt,
  input  logic                   d_uses_rs,
  input  logic                   d_uses_rt,
  input  logic [REG_ADDR_W-1:0]  d_rd,
  input  logic                   d_rwe,
  input  logic                   d_is_load,
  input  logic                   d_is_store,
  input  logic                   d_is_muldiv,
  input  logic                   d_reads_hilo,
  input  logic                   branch_taken,
  output logic                   stall,
  output logic                   flush_dx,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic                   fwd_wm,
  output logic                   muldiv_busy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  // Counter wide enough for MULDIV_LAT-1, never narrower than 3 bits.
  localparam int MD_W = ($clog2(MULDIV_LAT + 1) > 3) ? $clog2(MULDIV_LAT + 1) : 3;
  localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MULDIV_LAT - 1);

  // D/X holds the full tag; later stages keep only the fields still read
  // there (destination info everywhere, store-data rt in X/M).
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  uses_rs;
    logic                  uses_rt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rwe;
    logic                  is_load;
    logic                  is_store;
  } dx_tag_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rwe;
    logic                  is_load;
    logic                  is_store;
  } xm_tag_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rwe;
    logic                  is_load;
  } mw_tag_t;

  dx_tag_t               r_dx;
  xm_tag_t               r_xm;
  mw_tag_t               r_mw;
  logic [MD_W-1:0]       r_md_cnt;
  logic [STALL_CNT_W-1:0] r_stall_cycles;

  logic w_xm_wr_a;
  logic w_mw_wr_a;
  logic w_xm_wr_b;
  logic w_mw_wr_b;
  logic w_mw_wr_st;
  logic w_lu;
  logic w_md;
  logic w_busy;
  logic w_stall;
  logic w_dx_load;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // A stage "writes r" only when valid, writing, and r is not $0.
  assign w_xm_wr_a  = r_xm.valid & r_xm.rwe & (r_xm.rd == r_dx.rs) & (r_dx.rs != '0);
  assign w_mw_wr_a  = r_mw.valid & r_mw.rwe & (r_mw.rd == r_dx.rs) & (r_dx.rs != '0);
  assign w_xm_wr_b  = r_xm.valid & r_xm.rwe & (r_xm.rd == r_dx.rt) & (r_dx.rt != '0);
  assign w_mw_wr_b  = r_mw.valid & r_mw.rwe & (r_mw.rd == r_dx.rt) & (r_dx.rt != '0);
  assign w_mw_wr_st = r_mw.valid & r_mw.rwe & (r_mw.rd == r_xm.rt) & (r_xm.rt != '0);

  // MX forwarding is impossible from a load in X/M (data not ready yet);
  // the load-use stall guarantees that case never needs it.
  always_comb begin
    w_fwd_a = 2'b00;
    if (r_dx.uses_rs && w_xm_wr_a && !r_xm.is_load) w_fwd_a = 2'b01;
    else if (w_mw_wr_a)                             w_fwd_a = 2'b10;
    w_fwd_b = 2'b00;
    if (r_dx.uses_rt && w_xm_wr_b && !r_xm.is_load) w_fwd_b = 2'b01;
    else if (w_mw_wr_b)                             w_fwd_b = 2'b10;
  end

  // A store whose only dependence on the load is its rt data does not stall:
  // the loaded value reaches it in M through fwd_wm.
  assign w_lu = r_dx.valid & r_dx.is_load & r_dx.rwe & (r_dx.rd != '0) & d_valid &
                ((d_uses_rs & (d_rs == r_dx.rd)) |
                 (d_uses_rt & (d_rt == r_dx.rd) & !d_is_store));

  assign w_busy    = (r_md_cnt != '0);
  assign w_md      = w_busy & d_valid & (d_reads_hilo | d_is_muldiv);
  // A taken branch discards the F/D instruction, so its hazards are moot.
  assign w_stall   = (w_lu | w_md) & !branch_taken;
  assign w_dx_load = d_valid & !w_stall & !branch_taken;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dx           <= '0;
      r_xm           <= '0;
      r_mw           <= '0;
      r_md_cnt       <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_mw.valid   <= r_xm.valid;
      r_mw.rd      <= r_xm.rd;
      r_mw.rwe     <= r_xm.rwe;
      r_mw.is_load <= r_xm.is_load;

      r_xm.valid    <= r_dx.valid;
      r_xm.rt       <= r_dx.rt;
      r_xm.rd       <= r_dx.rd;
      r_xm.rwe      <= r_dx.rwe;
      r_xm.is_load  <= r_dx.is_load;
      r_xm.is_store <= r_dx.is_store;

      // Bubbles are fully cleared so stale specifiers can never match.
      if (w_dx_load) begin
        r_dx.valid    <= 1'b1;
        r_dx.rs       <= d_rs;
        r_dx.rt       <= d_rt;
        r_dx.uses_rs  <= d_uses_rs;
        r_dx.uses_rt  <= d_uses_rt;
        r_dx.rd       <= d_rd;
        r_dx.rwe      <= d_rwe;
        r_dx.is_load  <= d_is_load;
        r_dx.is_store <= d_is_store;
      end else begin
        r_dx <= '0;
      end

      // Only a MULT/DIV that actually enters D/X occupies HI/LO.
      if (w_dx_load && d_is_muldiv) r_md_cnt <= MD_LOAD;
      else if (w_busy)              r_md_cnt <= r_md_cnt - 1'b1;

      if (w_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  // Outputs are forced low while reset is held, even if inputs toggle.
  assign stall        = w_stall & !reset;
  assign flush_dx     = (w_stall | branch_taken) & !reset;
  assign fwd_a        = reset ? 2'b00 : w_fwd_a;
  assign fwd_b        = reset ? 2'b00 : w_fwd_b;
  assign fwd_wm       = r_xm.valid & r_xm.is_store & r_mw.is_load & w_mw_wr_st & !reset;
  assign muldiv_busy  = w_busy & !reset;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: per-cycle directed vectors, expected outputs
// pushed to a queue by the driver, popped and compared by a monitor.
module tb_hazard_ctrl;

  logic        clock;
  logic        reset;
  logic        d_valid;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic        d_uses_rs;
  logic        d_uses_rt;
  logic [4:0]  d_rd;
  logic        d_rwe;
  logic        d_is_load;
  logic        d_is_store;
  logic        d_is_muldiv;
  logic        d_reads_hilo;
  logic        branch_taken;
  logic        stall;
  logic        flush_dx;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        fwd_wm;
  logic        muldiv_busy;
  logic [31:0] stall_cycles;

  // {stall, flush_dx, fwd_a, fwd_b, fwd_wm, muldiv_busy, stall_cycles}
  logic [39:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc_no = 0;

  hazard_ctrl #(.REG_ADDR_W(5), .MULDIV_LAT(4), .STALL_CNT_W(32)) dut (
    .clock(clock), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt), .d_rd(d_rd), .d_rwe(d_rwe),
    .d_is_load(d_is_load), .d_is_store(d_is_store), .d_is_muldiv(d_is_muldiv),
    .d_reads_hilo(d_reads_hilo), .branch_taken(branch_taken), .stall(stall),
    .flush_dx(flush_dx), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_wm(fwd_wm),
    .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic set_d(input logic v, input logic [4:0] rs, rt, rd,
                       input logic urs, urt, rwe, ld, st, md, hilo);
    d_valid = v; d_rs = rs; d_rt = rt; d_rd = rd;
    d_uses_rs = urs; d_uses_rt = urt; d_rwe = rwe;
    d_is_load = ld; d_is_store = st; d_is_muldiv = md; d_reads_hilo = hilo;
  endtask

  task automatic op_nop();                           set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic op_add(input logic [4:0] rs, rt, rd); set_d(1, rs, rt, rd, 1, 1, 1, 0, 0, 0, 0); endtask
  task automatic op_lw(input logic [4:0] rs, rd);     set_d(1, rs, rd, rd, 1, 0, 1, 1, 0, 0, 0); endtask
  task automatic op_sw(input logic [4:0] rs, rt);     set_d(1, rs, rt, 0, 1, 1, 0, 0, 1, 0, 0); endtask
  task automatic op_div(input logic [4:0] rs, rt);    set_d(1, rs, rt, 0, 1, 1, 0, 0, 0, 1, 0); endtask
  task automatic op_mflo(input logic [4:0] rd);       set_d(1, 0, 0, rd, 0, 0, 1, 0, 0, 0, 1); endtask

  // Inputs for this cycle are already applied; record what the outputs
  // must be during this cycle, then advance to just after the next edge.
  task automatic cyc(input logic s, fl, input logic [1:0] fa, fb,
                     input logic wm, bz, input logic [31:0] sc);
    exp_q.push_back({s, fl, fa, fb, wm, bz, sc});
    @(posedge clock);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    logic [39:0] exp_v;
    logic [39:0] got_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {stall, flush_dx, fwd_a, fwd_b, fwd_wm, muldiv_busy, stall_cycles};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_%0d outputs: got s=%b fl=%b fa=%b fb=%b wm=%b busy=%b sc=%0d, expected s=%b fl=%b fa=%b fb=%b wm=%b busy=%b sc=%0d",
                 cyc_no, got_v[39], got_v[38], got_v[37:36], got_v[35:34], got_v[33], got_v[32], got_v[31:0],
                 exp_v[39], exp_v[38], exp_v[37:36], exp_v[35:34], exp_v[33], exp_v[32], exp_v[31:0]);
      end
      cyc_no++;
    end
  end

  initial begin
    reset = 1'b1;
    branch_taken = 1'b0;
    op_nop();
    repeat (2) @(posedge clock);
    #1;
    // Reset held: outputs low even with a branch and a real instruction.
    op_add(1, 2, 3); branch_taken = 1'b1;
    cyc(0, 0, 2'b00, 2'b00, 0, 0, 0);
    branch_taken = 1'b0;
    reset = 1'b0;

    // MX then WX forwarding
    op_add(1, 2, 3);  cyc(0, 0, 2'b00, 2'b00, 0, 0, 0);
    op_add(3, 5, 4);  cyc(0, 0, 2'b00, 2'b00, 0, 0, 0);
    op_add(3, 7, 6);  cyc(0, 0, 2'b01, 2'b00, 0, 0, 0);
    op_nop();         cyc(0, 0, 2'b10, 2'b00, 0, 0, 0);
    op_nop();         cyc(0, 0, 2'b00, 2'b00, 0, 0, 0);

    // load-use: one stall, then WX on both operands
    op_lw(1, 3);      cyc(0, 0, 2'b00, 2'b00, 0, 0, 0);
    op_add(3, 3, 4);  cyc(1, 1, 2'b00, 2'b00, 0, 0, 0);
    op_add(3, 3, 4);  cyc(0, 0, 2'b00, 2'b00, 0, 0, 1);
    op_nop();         cyc(0, 0, 2'b10, 2'b10, 0, 0, 1);
    op_nop();         cyc(0, 0, 2'b00, 2'b00, 0, 0, 1);

    // lw then sw of the loaded data: no stall, WM bypass two cycles later
    op_lw(1, 3);      cyc(0, 0, 2'b00, 2'b00, 0, 0, 1);
    op_sw(2, 3);      cyc(0, 0, 2'b00, 2'b00, 0, 0, 1);
    op_nop();         cyc(0, 0, 2'b00, 2'b00, 0, 0, 1);
    op_nop();         cyc(0, 0, 2'b00, 2'b00, 1, 0, 1);

    // lw then sw using the loaded register as base: stall
    op_lw(1, 3);      cyc(0, 0, 2'b00, 2'b00, 0, 0, 1);
    op_sw(3, 5);      cyc(1, 1, 2'b00, 2'b00, 0, 0, 1);
    op_sw(3, 5);      cyc(0, 0, 2'b00, 2'b00, 0, 0, 2);
    op_nop();         cyc(0, 0, 2'b10, 2'b00, 0, 0, 2);
    op_nop();         cyc(0, 0, 2'b00, 2'b00, 0, 0, 2);

    // div then mflo: three interlock cycles
    op_div(1, 2);     cyc(0, 0, 2'b00, 2'b00, 0, 0, 2);
    op_mflo(5);       cyc(1, 1, 2'b00, 2'b00, 0, 1, 2);
    op_mflo(5);       cyc(1, 1, 2'b00, 2'b00, 0, 1, 3);
    op_mflo(5);       cyc(1, 1, 2'b00, 2'b00, 0, 1, 4);
    op_mflo(5);       cyc(0, 0, 2'b00, 2'b00, 0, 0, 5);
    op_nop();         cyc(0, 0, 2'b00, 2'b00, 0, 0, 5);

    // taken branch over a blocked mflo and over a wrong-path div
    op_div(1, 2);     cyc(0, 0, 2'b00, 2'b00, 0, 0, 5);
    op_mflo(5); branch_taken = 1'b1;
                      cyc(0, 1, 2'b00, 2'b00, 0, 1, 5);
    op_div(1, 2);     cyc(0, 1, 2'b00, 2'b00, 0, 1, 5);
    op_nop(); branch_taken = 1'b0;
                      cyc(0, 0, 2'b00, 2'b00, 0, 1, 5);
    op_nop();         cyc(0, 0, 2'b00, 2'b00, 0, 0, 5);

    // taken branch over a load-use dependence
    op_lw(1, 3);      cyc(0, 0, 2'b00, 2'b00, 0, 0, 5);
    op_add(3, 3, 4); branch_taken = 1'b1;
                      cyc(0, 1, 2'b00, 2'b00, 0, 0, 5);
    op_nop(); branch_taken = 1'b0;
                      cyc(0, 0, 2'b00, 2'b00, 0, 0, 5);
    op_nop();         cyc(0, 0, 2'b00, 2'b00, 0, 0, 5);

    // $0 never forwards or stalls
    op_add(1, 2, 0);  cyc(0, 0, 2'b00, 2'b00, 0, 0, 5);
    op_add(0, 5, 4);  cyc(0, 0, 2'b00, 2'b00, 0, 0, 5);
    op_nop();         cyc(0, 0, 2'b00, 2'b00, 0, 0, 5);
    op_lw(1, 0);      cyc(0, 0, 2'b00, 2'b00, 0, 0, 5);
    op_add(0, 0, 4);  cyc(0, 0, 2'b00, 2'b00, 0, 0, 5);
    op_nop();         cyc(0, 0, 2'b00, 2'b00, 0, 0, 5);

    // reset in the middle of a div interlock
    op_div(1, 2);     cyc(0, 0, 2'b00, 2'b00, 0, 0, 5);
    op_mflo(5);       cyc(1, 1, 2'b00, 2'b00, 0, 1, 5);
    reset = 1'b1;     cyc(0, 0, 2'b00, 2'b00, 0, 0, 0);
    reset = 1'b0; op_add(3, 3, 4);
                      cyc(0, 0, 2'b00, 2'b00, 0, 0, 0);
    op_nop();         cyc(0, 0, 2'b00, 2'b00, 0, 0, 0);

    // reset in the middle of a load-use stall
    op_lw(1, 3);      cyc(0, 0, 2'b00, 2'b00, 0, 0, 0);
    op_add(3, 3, 4);  cyc(1, 1, 2'b00, 2'b00, 0, 0, 0);
    reset = 1'b1;     cyc(0, 0, 2'b00, 2'b00, 0, 0, 0);
    reset = 1'b0;     cyc(0, 0, 2'b00, 2'b00, 0, 0, 0);
    op_nop();         cyc(0, 0, 2'b00, 2'b00, 0, 0, 0);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline. It replaces the ad hoc bypass and stall equations with a single sequential block. The block keeps its own destination and source tags for the D/X, X/M and M/W stages. It drives MX/WX forwarding selects for the instruction in D/X, the WM store-data bypass for X/M, the load-use stall, and a multi-cycle MULT/DIV interlock on HI/LO. It also keeps a stall-cycle performance counter.

Parameters:
REG_ADDR_W, 5, register specifier width
MULDIV_LAT, 4, cycles a MULT/DIV occupies the HI/LO unit (≥1)
STALL_CNT_W, 32, width of stall-cycle counter

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
d_valid  in  1  F/D holds a real instruction
d_rs  in  REG_ADDR_W  decode source A specifier
d_rt  in  REG_ADDR_W  decode source B specifier
d_uses_rs  in  1  decode instruction reads rs
d_uses_rt  in  1  decode instruction reads rt
d_rd  in  REG_ADDR_W  resolved destination (rd or rt per rdst)
d_rwe  in  1  decode instruction writes regfile
d_is_load  in  1  LW/LB/LBU
d_is_store  in  1  SW/SB (rt is store data)
d_is_muldiv  in  1  MULT/DIV
d_reads_hilo  in  1  MFHI/MFLO
branch_taken  in  1  execute resolved taken branch/jump this cycle
stall  out  1  hold PC and F/D, bubble into D/X
flush_dx  out  1  load bubble into D/X
fwd_a  out  2  D/X operand A select: 00 regfile, 01 MX, 10 WX
fwd_b  out  2  D/X operand B select, same encoding
fwd_wm  out  1  X/M store data taken from writeback value
muldiv_busy  out  1  HI/LO unit occupied
stall_cycles  out  STALL_CNT_W  count of cycles with stall=1

Behaviour:
- Reset (async): all stage tags invalid, muldiv counter 0, stall_cycles 0.
- While reset is asserted, all outputs are 0.
- Per-stage tag contents: valid, rs, rt, uses_rs, uses_rt, rd, rwe, is_load, is_store.
- Tags advance on posedge: MW<=XM, XM<=DX.
- DX loads a bubble (valid=0) if branch_taken, stall, or !d_valid; otherwise DX loads the decode inputs.
- Writer match rule: a stage "writes r" iff valid & rwe & rd==r & r!=0. Register 0 never forwards or stalls.
- fwd_a, combinational on DX:
  - 01 if DX.uses_rs and XM writes DX.rs and !XM.is_load;
  - else 10 if MW writes DX.rs;
  - else 00.
  - MX has priority over WX.
- fwd_b: same rule using DX.uses_rt/DX.rt. This applies to stores too; the forwarded rt becomes the store data.
- fwd_wm = XM.valid & XM.is_store & MW writes XM.rt & !(fwd already consumed in X). In practice: MW.is_load & MW writes XM.rt.
- Load-use stall (lu): DX.is_load & DX.valid & DX.rwe & DX.rd!=0 & d_valid, and either:
  - d_uses_rs & d_rs==DX.rd, or
  - d_uses_rt & d_rt==DX.rd & !d_is_store.
  - A store whose only dependence is its rt data does not stall; it is served by fwd_wm.
  - lu lasts exactly one cycle per dependence.
- MULT/DIV interlock:
  - A 3-bit-or-wider counter is loaded with MULDIV_LAT-1 when a d_is_muldiv instruction enters DX (not stalled, not flushed).
  - Otherwise the counter decrements toward 0 and holds at 0.
  - muldiv_busy = counter!=0.
  - md = muldiv_busy & d_valid & (d_reads_hilo | d_is_muldiv).
  - With MULDIV_LAT=1, md never asserts.
- stall = (lu | md) & !branch_taken. A taken branch overrides: the F/D instruction is wrong-path and is discarded.
- flush_dx = stall | branch_taken.
- stall_cycles increments each cycle stall=1 and saturates at all-ones.
- Simultaneous lu and md: single stall. Both conditions re-evaluate each cycle.
- A wrong-path MULT/DIV flushed by branch_taken does not load the counter.
- reset mid-MULT/DIV: muldiv_busy drops immediately (async).

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 → next cycle fwd_a=01, fwd_b=00; a second dependent instruction one slot later gets fwd_a=10.
- lw $3,0($1) then add $4,$3,$3 → stall=1 and flush_dx=1 for exactly 1 cycle, then fwd_a=10, fwd_b=10; stall_cycles=1.
- lw $3,0($1) then sw $3,4($2) → no stall; 2 cycles later fwd_wm=1. sw with base $3 instead → 1-cycle stall.
- MULDIV_LAT=4: div $1,$2 then mflo $5 → muldiv_busy high 3 cycles, stall=1 for 3 cycles, mflo enters DX on cycle 4; stall_cycles=3.
- branch_taken=1 while decode is lw-dependent or mflo-blocked → stall=0, flush_dx=1, DX bubble, counter unchanged. Writes to $0 never forward (fwd_a=00).
- Assert reset mid-DIV and mid-stall → all outputs 0 asynchronously, stall_cycles=0; after release, the first instruction has no forwarding.
